// File: rtl/hazard_scoreboard_if.sv
// Issue/write-back/flush bundle between decode and the hazard scoreboard.
// The master side drives the decode and write-back requests; the slave side returns the stall and forwarding verdicts.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            iss_valid;
  logic [AW-1:0]   iss_rs1;
  logic [AW-1:0]   iss_rs2;
  logic [AW-1:0]   iss_rd;
  logic            iss_rd_wen;
  logic [CW-1:0]   iss_lat;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic            flush;
  logic            iss_stall;
  logic            fwd_hit1;
  logic            fwd_hit2;
  logic [NREG-1:0] busy_vec;
  logic [31:0]     stall_cnt;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen, iss_lat,
    output wb_valid, wb_rd, flush,
    input  iss_stall, fwd_hit1, fwd_hit2, busy_vec, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen, iss_lat,
    input  wb_valid, wb_rd, flush,
    output iss_stall, fwd_hit1, fwd_hit2, busy_vec, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: each register has a pending-write bit and a latency countdown; the scoreboard stalls issue on RAW and WAW hazards.
// Define SB_FORWARD_EN to let operands whose countdown has reached 0 take bypass data instead of stalling.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 7,
  parameter int CW      = 3
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave sb
);

  localparam int NADDR = 2**AW;

  logic [NREG-1:1] r_busy;
  logic [CW-1:0]   r_cnt [NREG-1:1];
  logic [31:0]     r_stall_cnt;

  logic [NADDR-1:0] w_busy_ext;
  logic [CW-1:0]    w_lat;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_waw;
  logic             w_stall;
  logic             w_accept;
  logic             w_fwd1;
  logic             w_fwd2;

  // x0 and addresses beyond NREG read as never busy
  always_comb begin
    w_busy_ext = '0;
    for (int i = 1; i < NREG; i++) begin
      w_busy_ext[i] = r_busy[i];
    end
  end

  generate
    if (MAX_LAT < (2**CW) - 1) begin : g_lat_clamp
      assign w_lat = (sb.iss_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : sb.iss_lat;
    end else begin : g_lat_pass
      assign w_lat = sb.iss_lat;
    end
  endgenerate

`ifdef SB_FORWARD_EN
  logic [NADDR-1:0] w_cnt_zero_ext;

  always_comb begin
    w_cnt_zero_ext = '1;
    for (int i = 1; i < NREG; i++) begin
      w_cnt_zero_ext[i] = (r_cnt[i] == '0);
    end
  end

  // A busy source whose result is already bypassable is forwarded instead of stalled
  always_comb begin
    w_haz1 = w_busy_ext[sb.iss_rs1] && !w_cnt_zero_ext[sb.iss_rs1];
    w_haz2 = w_busy_ext[sb.iss_rs2] && !w_cnt_zero_ext[sb.iss_rs2];
    w_fwd1 = sb.iss_valid && w_busy_ext[sb.iss_rs1] && w_cnt_zero_ext[sb.iss_rs1];
    w_fwd2 = sb.iss_valid && w_busy_ext[sb.iss_rs2] && w_cnt_zero_ext[sb.iss_rs2];
  end
`else
  always_comb begin
    w_haz1 = w_busy_ext[sb.iss_rs1];
    w_haz2 = w_busy_ext[sb.iss_rs2];
    w_fwd1 = 1'b0;
    w_fwd2 = 1'b0;
  end
`endif

  always_comb begin
    w_waw    = sb.iss_rd_wen && w_busy_ext[sb.iss_rd];
    w_stall  = sb.iss_valid && (w_haz1 || w_haz2 || w_waw);
    w_accept = sb.iss_valid && !w_stall;
  end

  // flush beats issue, and issue beats write-back to the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      for (int i = 1; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (sb.flush) begin
      r_busy <= '0;
      for (int i = 1; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_accept && sb.iss_rd_wen && (sb.iss_rd == AW'(i))) begin
          r_busy[i] <= 1'b1;
          r_cnt[i]  <= w_lat;
        end else if (sb.wb_valid && (sb.wb_rd == AW'(i))) begin
          r_busy[i] <= 1'b0;
          r_cnt[i]  <= '0;
        end else if (r_busy[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sb.iss_stall = w_stall;
  assign sb.fwd_hit1  = w_fwd1;
  assign sb.fwd_hit2  = w_fwd2;
  assign sb.busy_vec  = {r_busy, 1'b0};
  assign sb.stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers tracked (x0 included, never tracked).
REQ-002 SHALL have parameter AW, default 5, meaning register address width; NREG <= 2**AW.
REQ-003 SHALL have parameter MAX_LAT, default 7, meaning longest issue-to-forwardable latency in cycles.
REQ-004 SHALL have parameter CW, default 3, meaning per-register countdown width; 2**CW > MAX_LAT.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port iss_valid  input  1  decode stage presents an instruction.
REQ-008 SHALL have ports iss_rs1, iss_rs2  input  AW each  source register addresses.
REQ-009 SHALL have port iss_rd  input  AW  destination register address.
REQ-010 SHALL have port iss_rd_wen  input  1  instruction writes iss_rd.
REQ-011 SHALL have port iss_lat  input  CW  cycles until result is bypassable (0 = ALU result next cycle).
REQ-012 SHALL have port wb_valid  input  1  write-back stage commits a register write.
REQ-013 SHALL have port wb_rd  input  AW  write-back destination.
REQ-014 SHALL have port flush  input  1  clear all pending entries.
REQ-015 SHALL have port iss_stall  output  1  combinational; issue blocked this cycle.
REQ-016 SHALL have ports fwd_hit1, fwd_hit2  output  1 each  combinational; rs1/rs2 must take bypass data.
REQ-017 SHALL have port busy_vec  output  NREG  registered pending-write bit per register.
REQ-018 SHALL have port stall_cnt  output  32  registered count of stalled cycles.

Function
REQ-019 SHALL hold per register r (1..NREG-1) a busy bit and a CW-bit countdown cnt[r]; register 0 SHALL read as never busy.
REQ-020 Issue is accepted when iss_valid=1 and iss_stall=0; only accepted issues update state.
REQ-021 On accepted issue with iss_rd_wen=1 and iss_rd!=0, the next cycle SHALL have busy[iss_rd]=1 and cnt[iss_rd]=min(iss_lat, MAX_LAT).
REQ-022 Each cycle, every busy entry with cnt>0 and not being re-issued SHALL decrement by 1; cnt SHALL saturate at 0.
REQ-023 wb_valid=1 with wb_rd!=0 SHALL clear busy[wb_rd] and cnt[wb_rd] next cycle.
REQ-024 Same-cycle accepted issue and write-back to the same register: issue SHALL win (entry set per REQ-021).
REQ-025 Source operand s is hazardous when s!=0 and busy[s]=1 with cnt[s]>0 (RAW, forwarding feature in) or busy[s]=1 (feature out).
REQ-026 iss_stall SHALL be 1 when iss_valid=1 and (rs1 hazardous, or rs2 hazardous, or (iss_rd_wen=1, iss_rd!=0, busy[iss_rd]=1)) -- WAW always stalls.
REQ-027 iss_stall SHALL be 0 when iss_valid=0; hazard evaluation SHALL use registered state only, no same-cycle write-back bypass.
REQ-028 flush=1 SHALL clear all busy and cnt next cycle and SHALL have priority over a same-cycle issue and write-back; iss_stall is still evaluated normally in that cycle.
REQ-029 stall_cnt SHALL increment by 1 each cycle iss_stall=1 and saturate at 32'hFFFF_FFFF; flush SHALL NOT clear it.
REQ-030 busy_vec[0] SHALL be constant 0.

Reset
REQ-031 rst=0 SHALL asynchronously clear all busy bits, all cnt, and stall_cnt to 0; iss_stall, fwd_hit1, fwd_hit2 SHALL then be 0.
REQ-032 Reset mid-operation SHALL discard all pending entries; no write-back is required to recover.

Configuration
REQ-033 Macro SB_FORWARD_EN defined: fwd_hitN = (rsN!=0, busy[rsN]=1, cnt[rsN]=0, iss_valid=1); such operands do not stall.
REQ-034 SB_FORWARD_EN undefined: fwd_hit1 and fwd_hit2 SHALL be tied 0 and any busy source stalls until its write-back clears it.

Verification
REQ-035 Issue rd=5, lat=0; next cycle issue rs1=5 -> with SB_FORWARD_EN: iss_stall=0, fwd_hit1=1; without: iss_stall=1 until cycle after wb_rd=5.
REQ-036 Issue rd=7, lat=2; issue rs2=7 each cycle -> iss_stall=1 for exactly 2 cycles, then 0 with fwd_hit2=1 (macro on); stall_cnt=2.
REQ-037 rd=3 busy; issue rd=3 (WAW) -> iss_stall=1; wb_rd=3 -> next cycle iss_stall=0.
REQ-038 Same cycle: accepted issue rd=9 lat=3 and wb_rd=9 -> busy_vec[9]=1, cnt=3 next cycle.
REQ-039 Issue rd=0 lat=5; then rs1=0 -> busy_vec=0, iss_stall=0, fwd_hit1=0.
REQ-040 busy_vec=32'h0000_00F0, assert flush one cycle then rst=0 mid-countdown -> busy_vec=0 after each; stall_cnt unchanged by flush, 0 after reset.
